// File: rtl/input_cond_pkg.sv
// Shared constants and helpers for the input conditioner: default debounce
// window, idle levels for each kind of pin, and a constant-safe clog2.
package input_cond_pkg;

    localparam int CLK_HZ            = 50_000_000;
    localparam int DB_MS             = 10;
    localparam int DB_CYCLES_DEFAULT = (CLK_HZ / 1000) * DB_MS;

    // Idle pin levels: switches rest low; active-low buttons rest high.
    localparam logic SW_INACTIVE            = 1'b0;
    localparam logic BTN_INACTIVE_ACTIVE_LO = 1'b1;
    localparam logic BTN_INACTIVE_ACTIVE_HI = 1'b0;

    // Released level of a button for the given polarity.
    function automatic logic btn_inactive(input bit active_low);
        return active_low ? BTN_INACTIVE_ACTIVE_LO : BTN_INACTIVE_ACTIVE_HI;
    endfunction

    // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Pin-side and PIO-side signals of the input conditioner. The master drives
// the raw pins; the slave (the conditioner) drives the cleaned levels/pulses.
interface input_conditioner_if #(
    parameter int N_BTN = 4,
    parameter int N_SW  = 10
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_SW-1:0]  sw_raw;
    logic [N_BTN-1:0] btn_clean;
    logic [N_SW-1:0]  sw_clean;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_SW-1:0]  sw_changed;

    modport master (
        output btn_raw, sw_raw,
        input  btn_clean, sw_clean, btn_press, btn_release, sw_changed
    );

    modport slave (
        input  btn_raw, sw_raw,
        output btn_clean, sw_clean, btn_press, btn_release, sw_changed
    );
endinterface

// File: rtl/input_conditioner_debounce_bit.sv
// One debounced channel: 2-FF synchroniser, stability counter, accepted level
// register and single-cycle rise/fall pulses aligned with the level change.
module debounce_bit
    import input_cond_pkg::*;
#(
    parameter int   DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int                 CNT_W    = clog2(DB_CYCLES) + 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous pin into the clock domain.
    // NOTE: reset is synchronous (sampled only on the clock edge) and the
    // synchroniser flops load the idle level so nothing looks like an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= RESET_LEVEL;
            s2 <= RESET_LEVEL;
        end else begin
            // NOTE: non-blocking assignments so s2 takes the old s1, giving
            // two real flop stages rather than one.
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Count consecutive mismatching cycles; accept the new level after a
    // full window and emit the matching edge pulse for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= RESET_LEVEL;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= s2;
                cnt    <= '0;
                rise   <= s2;
                fall   <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = stable;

endmodule

// File: rtl/input_conditioner.sv
// Debounces N_BTN buttons and N_SW switches for the Nios PIOs. Button edges
// are mapped to press/release by polarity; switch edges both count as change.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int N_BTN          = 4,
    parameter int N_SW           = 10,
    parameter int DB_CYCLES      = DB_CYCLES_DEFAULT,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input_conditioner_if.slave   bus
);
    localparam logic BTN_IDLE = btn_inactive(BTN_ACTIVE_LOW);

    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN-1:0] btn_fall;
    logic [N_SW-1:0]  sw_level;
    logic [N_SW-1:0]  sw_rise;
    logic [N_SW-1:0]  sw_fall;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_bit #(
            .DB_CYCLES   (DB_CYCLES),
            .RESET_LEVEL (BTN_IDLE)
        ) u_db (
            .clk   (clk_clk),
            .rst   (reset_reset),
            .raw   (bus.btn_raw[i]),
            .level (btn_level[i]),
            .rise  (btn_rise[i]),
            .fall  (btn_fall[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(
            .DB_CYCLES   (DB_CYCLES),
            .RESET_LEVEL (SW_INACTIVE)
        ) u_db (
            .clk   (clk_clk),
            .rst   (reset_reset),
            .raw   (bus.sw_raw[i]),
            .level (sw_level[i]),
            .rise  (sw_rise[i]),
            .fall  (sw_fall[i])
        );
    end

    // Levels keep raw pin polarity; a press is the edge toward the active level.
    assign bus.btn_clean   = btn_level;
    assign bus.sw_clean    = sw_level;
    assign bus.btn_press   = BTN_ACTIVE_LOW ? btn_fall : btn_rise;
    assign bus.btn_release = BTN_ACTIVE_LOW ? btn_rise : btn_fall;
    // Rise and fall are mutually exclusive flop outputs, so this never glitches
    // from the pins.
    assign bus.sw_changed  = sw_rise | sw_fall;

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Synchronises and debounces the raw push-button and slide-switch pins before they reach the Nios system's button and switch PIO inputs, and generates single-cycle press/release/change pulses. Sits directly upstream of `button_external_connection_export` and `switch_external_connection_export`. Outputs preserve raw pin polarity, so the PIO wiring is a drop-in replacement for direct pin connections.

## Interface
- `N_BTN`, 4, number of push-button channels
- `N_SW`, 10, number of slide-switch channels
- `DB_CYCLES`, 500000, consecutive stable clock cycles required to accept a new level (10 ms at 50 MHz); legal range ≥1
- `BTN_ACTIVE_LOW`, 1, 1: raw button pin reads 0 when pressed

- `clk_clk` in 1: system clock; all logic on its rising edge
- `reset_reset` in 1: synchronous reset, active-high
- `btn_raw` in N_BTN: asynchronous button pins
- `sw_raw` in N_SW: asynchronous switch pins
- `btn_clean` out N_BTN: debounced button level, raw polarity, to button PIO
- `sw_clean` out N_SW: debounced switch level, to switch PIO
- `btn_press` out N_BTN: 1-cycle pulse when a button becomes pressed
- `btn_release` out N_BTN: 1-cycle pulse when a button becomes released
- `sw_changed` out N_SW: 1-cycle pulse on any accepted switch level change

## Operation
- Per channel: 2-FF synchroniser (`s1`, `s2`), counter `cnt` (width clog2(DB_CYCLES)+1), registered `stable`.
- Each cycle: if `s2 == stable`, `cnt <= 0`. Else if `cnt == DB_CYCLES-1`, `stable <= s2`, `cnt <= 0`, assert the channel's event pulse. Else `cnt <= cnt+1`.
- Any return of `s2` to `stable` before acceptance clears `cnt`; bounce restarts the window. Glitches shorter than DB_CYCLES cycles never reach outputs.
- Press = `stable` transitions to pressed level (0 if BTN_ACTIVE_LOW, else 1); release = opposite transition. Press and release for one channel never assert in the same cycle.
- `sw_changed[i]` pulses on both switch directions.
- Channels independent; simultaneous events on several channels each produce their own pulse in the same cycle.
- `cnt` never exceeds DB_CYCLES-1; no wrap.
- Reset values: `s1`, `s2`, `stable` = inactive level (buttons released: all 1s if BTN_ACTIVE_LOW; switches 0); `cnt` = 0; all pulse outputs 0. Hence `btn_clean` resets to released and `sw_clean` to 0.
- A switch physically at 1 during reset is accepted DB_CYCLES+2 cycles after reset deasserts, producing one `sw_changed` pulse. This is required, so software sees the initial state.
- Reset asserted mid-count discards the pending change. Reset has priority over every update.

## Timing
- Raw pin settles before edge 0: `s1` updates at edge 0, `s2` at edge 1, first mismatch counted at edge 2.
- `stable`, `*_clean` and pulse change together at edge DB_CYCLES+1. Pulse is high for exactly one cycle.
- All outputs registered; no combinational path from `*_raw` to any output.
- Input ignored while mismatch persists for fewer than DB_CYCLES cycles.

## Structure
- Package `input_cond_pkg`: default constants (`CLK_HZ = 50_000_000`, `DB_MS = 10`, derived `DB_CYCLES_DEFAULT`), inactive-level constants for buttons/switches, `clog2` helper.
- Sub-module `debounce_bit` (one channel: synchroniser, counter, stable register, rise/fall pulses; parameters `DB_CYCLES`, `RESET_LEVEL`). Top generates N_BTN + N_SW instances and maps rise/fall to press/release according to BTN_ACTIVE_LOW.

## Test plan
All with DB_CYCLES=4, BTN_ACTIVE_LOW=1.
- Reset held 3 cycles with all raw inputs at inactive level -> `btn_clean`=4'hF, `sw_clean`=0, no pulses for 20 cycles after release.
- `btn_raw[0]` 1→0 before edge 0, held -> `btn_clean[0]`=0 and `btn_press[0]` high for one cycle at edge 5; `btn_release` stays 0. Return to 1 -> `btn_release[0]` pulse 5 edges later.
- Bounce: `btn_raw[1]` toggles 0,1,0 at 2-cycle intervals then holds 0 -> exactly one `btn_press[1]` pulse, 5 edges after the final transition.
- Glitch: `sw_raw[3]` high for 3 cycles -> `sw_clean[3]` stays 0, `sw_changed` never asserts.
- Simultaneous: `sw_raw` 0→10'h3FF and `btn_raw` 4'hF→4'h0 before the same edge -> all 14 pulses assert in the same cycle at edge 5.
- Reset mid-count: `sw_raw[0]` 0→1, reset asserted at edge 3 for one cycle with the input held -> no pulse before reset; `sw_changed[0]` fires 6 edges after reset deasserts.
